xz_result_serializer: RTL and testbench
=======================================

Name: xz_result_serializer

Overview:
- Downstream stage of the circuit2 datapath. Consumes the registered signed result pair (x, z) each time the wrapper flags it valid.
- Buffers pairs in a small FIFO, then emits each pair as two DATA_W words on a valid/ready stream: x first, then z with out_last set.
- Keeps a wrapping count of completed pairs and a wrapping signed sum of emitted z values.

Parameters:
- DATA_W, 32, width of x, z and out_data. Matches the circuit2 datapath width.
- DEPTH, 4, FIFO entries (pairs). Power of two, at least 2.
- CNT_W, 16, width of pair_count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low; 0 resets all state.
- in_valid  in  1  a pair is presented on in_x/in_z. Driven by the wrapper's valid delayed one cycle to align with the x/z REG outputs.
- in_ready  out  1  FIFO can accept a pair.
- in_x  in  DATA_W  signed x result.
- in_z  in  DATA_W  signed z result.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_W  x or z word.
- out_last  out  1  1 when out_data is the z word (end of pair).
- fifo_level  out  log2(DEPTH)+1  pairs currently stored.
- pair_count  out  CNT_W  completed pairs emitted; wraps modulo 2^CNT_W.
- z_sum  out  DATA_W  signed sum of all emitted z; two's-complement wrap, no saturation.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO empty, so in_ready=1, out_valid=0, out_data=0, out_last=0.
  - fifo_level=0, pair_count=0, z_sum=0, FSM in SEND_X.
- Push: in_valid & in_ready at a clock edge writes {in_x,in_z} at the write pointer and increments it.
  - in_ready = !full, derived from registered state only. It never depends on a same-cycle pop, so there is no push-through when full.
- FSM has two states:
  - SEND_X: out_data=head.x, out_last=0. On out_valid & out_ready, go to SEND_Z; no pop.
  - SEND_Z: out_data=head.z, out_last=1. On out_valid & out_ready, pop the head, go to SEND_X, pair_count += 1, z_sum += head.z.
- out_valid = !empty. When empty, out_data=0 and out_last=0; the state holds.
- Latency: a pair pushed at edge N into an empty FIFO gives out_valid=1 with x during cycle N+1. With out_ready held high, z follows in N+2.
- Throughput: at most one pair per 2 cycles on the output. The input sustains one pair per cycle until full.
- Simultaneous push and pop (not full, not empty): both occur and fifo_level is unchanged.
- Push into an empty FIFO while in SEND_X: the head becomes valid next cycle. No combinational in-to-out path.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by the extra MSB of fifo_level (or of the pointers).
- out_ready low: out_data, out_last and out_valid hold stable; stream rules forbid changing a presented word.
- in_valid while full: no write and no state change. The upstream holds its data (wrapper stalls circuit2 by gating its REG update).
- Reset mid-pair: a pair already half-emitted (x sent, z pending) is discarded. After release, output resumes at SEND_X of the next pushed pair.
- Arithmetic: z_sum uses signed DATA_W addition, carry discarded (0x7FFFFFFF + 1 gives 0x80000000). pair_count wraps from 2^CNT_W-1 to 0.

Decomposition:
- Shared package: DATA_W default 32; state encoding constants ST_SEND_X=1'b0, ST_SEND_Z=1'b1; function clog2 for level/pointer widths.
- One sub-module: xz_pair_fifo, a synchronous FIFO 2*DATA_W wide and DEPTH deep with push, pop, full, empty and level.
- The top level holds the FSM, out_last logic and the pair_count/z_sum counters.

Test Plan:
- Reset then single pair: x=0x00000005, z=0xFFFFFFFE pushed, out_ready=1 -> cycle+1 out_data=5, last=0; cycle+2 out_data=0xFFFFFFFE, last=1; pair_count=1, z_sum=0xFFFFFFFE.
- Fill: push 5 pairs back-to-back with out_ready=0 -> in_ready drops after 4th accept, fifo_level=4, 5th held. Raise out_ready -> 8 words emitted in order, 5th pair accepted once level<4.
- Backpressure: toggle out_ready 1/0 every cycle -> out_data stable while stalled, x/z order and last flags preserved, no loss or duplication.
- Concurrent push/pop at level 2 -> level stays 2 across the z-pop cycle. Contents are FIFO ordered.
- Wrap: z_sum preloaded by pairs z=0x7FFFFFFF then z=1 -> z_sum=0x80000000. 65536 pairs with CNT_W=16 -> pair_count=0.
- Async reset asserted between x and z handshakes -> outputs zero immediately without a clock edge. After release, the next pair starts with x and pair_count=0.

Source files
------------

// File: rtl/xz_result_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xz_result_serializer_pkg
// Description : Shared types, constants and helpers for the x/z result
//               serializer (FSM state encoding, default datapath width,
//               ceiling-log2 for pointer/level widths).
// Revision    : 1.0 - initial release
// ============================================================================
package xz_result_serializer_pkg;

  // Default datapath width, matching the circuit2 result registers.
  localparam int DATA_W_DEF = 32;

  // Output sequencer: x word first, then z word flagged as last.
  typedef enum logic [0:0] {
    ST_SEND_X = 1'b0,
    ST_SEND_Z = 1'b1
  } state_e;

  // Ceiling log2, used only at elaboration time for pointer widths.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage : xz_result_serializer_pkg
`default_nettype wire

// File: rtl/xz_pair_fifo.sv
`default_nettype none
// ============================================================================
// Module      : xz_pair_fifo
// Description : Synchronous FIFO, WIDTH bits wide and DEPTH entries deep.
//               Pointers carry one extra MSB so that full and empty are told
//               apart by the occupancy count alone.
// Ports       : clk      - rising-edge clock
//               rst      - asynchronous reset, active-low
//               push_i   - write wdata_i (ignored while full)
//               pop_i    - drop the head entry (ignored while empty)
//               wdata_i  - write data
//               rdata_o  - head entry (valid while !empty_o)
//               full_o   - DEPTH entries stored
//               empty_o  - no entries stored
//               level_o  - entries currently stored
// Revision    : 1.0 - initial release
// ============================================================================
module xz_pair_fifo
  import xz_result_serializer_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [WIDTH-1:0]        wdata_i,
  output logic [WIDTH-1:0]        rdata_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [clog2(DEPTH):0]   level_o
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Occupancy never exceeds DEPTH, so its MSB is set only when full.
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = level_o[AW];
  assign empty_o = (level_o == '0);

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  // Storage is cleared on reset so the head never presents X.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule : xz_pair_fifo
`default_nettype wire

// File: rtl/xz_result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : xz_result_serializer
// Description : Buffers signed (x, z) result pairs and streams each pair as
//               two words on a valid/ready interface, x first, then z with
//               out_last. Keeps a wrapping completed-pair count and a
//               wrapping signed sum of emitted z values.
// Ports       : clk        - rising-edge clock
//               rst        - asynchronous reset, active-low
//               in_valid   - pair presented on in_x/in_z
//               in_ready   - a pair can be accepted (registered state only)
//               in_x/in_z  - signed x / z results
//               out_valid  - out_data holds a valid word
//               out_ready  - consumer accepts the word
//               out_data   - x or z word
//               out_last   - out_data is the z word
//               fifo_level - pairs currently stored
//               pair_count - completed pairs emitted (wraps)
//               z_sum      - sum of emitted z (two's-complement wrap)
// Revision    : 1.0 - initial release
// ============================================================================
module xz_result_serializer
  import xz_result_serializer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_x,
  input  logic [DATA_W-1:0]     in_z,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  output logic [clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]      pair_count,
  output logic [DATA_W-1:0]     z_sum
);

  state_e              state_q;
  state_e              state_d;
  logic [CNT_W-1:0]    pair_count_q;
  logic [CNT_W-1:0]    pair_count_d;
  logic [DATA_W-1:0]   z_sum_q;
  logic [DATA_W-1:0]   z_sum_d;

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [2*DATA_W-1:0] fifo_rdata;
  logic [DATA_W-1:0]   head_x;
  logic [DATA_W-1:0]   head_z;

  xz_pair_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .pop_i   (fifo_pop),
    .wdata_i ({in_x, in_z}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign head_x = fifo_rdata[2*DATA_W-1:DATA_W];
  assign head_z = fifo_rdata[DATA_W-1:0];

  // Ready comes from the registered full flag only; a pop in the same cycle
  // does not open a slot until the next edge.
  assign in_ready   = ~fifo_full;
  assign out_valid  = ~fifo_empty;
  assign pair_count = pair_count_q;
  assign z_sum      = z_sum_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_SEND_X;
      pair_count_q <= '0;
      z_sum_q      <= '0;
    end else begin
      state_q      <= state_d;
      pair_count_q <= pair_count_d;
      z_sum_q      <= z_sum_d;
    end
  end

  // The head entry only leaves the FIFO once its z word is accepted, so a
  // stalled consumer always sees the same word until it takes it.
  always_comb begin
    state_d      = state_q;
    pair_count_d = pair_count_q;
    z_sum_d      = z_sum_q;
    fifo_pop     = 1'b0;
    out_data     = '0;
    out_last     = 1'b0;
    if (!fifo_empty) begin
      case (state_q)
        ST_SEND_X: begin
          out_data = head_x;
          if (out_ready) begin
            state_d = ST_SEND_Z;
          end
        end
        ST_SEND_Z: begin
          out_data = head_z;
          out_last = 1'b1;
          if (out_ready) begin
            fifo_pop     = 1'b1;
            state_d      = ST_SEND_X;
            pair_count_d = pair_count_q + CNT_W'(1);
            z_sum_d      = z_sum_q + head_z;
          end
        end
        default: begin
          state_d = ST_SEND_X;
        end
      endcase
    end
  end

endmodule : xz_result_serializer
`default_nettype wire

// File: tb/tb_xz_result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_xz_result_serializer
// Description : Self-checking bench for xz_result_serializer. A word-level
//               reference (queue of {last, data} words) predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xz_result_serializer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_x = '0;
  logic [DATA_W-1:0] in_z = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [2:0]        fifo_level;
  logic [CNT_W-1:0]  pair_count;
  logic [DATA_W-1:0] z_sum;

  int tests = 0;
  int fails = 0;

  // Reference: pending source pairs and the stream of words still owed.
  logic [2*DATA_W-1:0] src_q[$];
  logic [DATA_W:0]     words_q[$];
  int                  ref_pairs = 0;
  logic [DATA_W-1:0]   ref_zsum = '0;

  always #5 clk = ~clk;

  xz_result_serializer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_z       (in_z),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .fifo_level (fifo_level),
    .pair_count (pair_count),
    .z_sum      (z_sum)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_level();
    return (words_q.size() + 1) / 2;
  endfunction

  task automatic check_all();
    logic              ev;
    logic [DATA_W:0]   hw;
    ev = (words_q.size() != 0);
    hw = ev ? words_q[0] : '0;
    chk("out_valid",  64'(out_valid),  64'(ev));
    chk("out_data",   64'(out_data),   64'(hw[DATA_W-1:0]));
    chk("out_last",   64'(out_last),   64'(hw[DATA_W]));
    chk("fifo_level", 64'(fifo_level), 64'(exp_level()));
    chk("in_ready",   64'(in_ready),   64'(exp_level() < DEPTH));
    chk("pair_count", 64'(pair_count), 64'(ref_pairs % (1 << CNT_W)));
    chk("z_sum",      64'(z_sum),      64'(ref_zsum));
  endtask

  // One clock: drive, check at the falling edge, advance the reference at
  // the rising edge.
  task automatic cycle();
    logic            do_push;
    logic            do_pop;
    logic [DATA_W:0] w;
    in_valid = (src_q.size() != 0);
    in_x     = in_valid ? src_q[0][2*DATA_W-1:DATA_W] : '0;
    in_z     = in_valid ? src_q[0][DATA_W-1:0] : '0;
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (rst_n) begin
      do_push = in_valid && (exp_level() < DEPTH);
      do_pop  = (words_q.size() != 0) && out_ready;
      if (do_pop) begin
        w = words_q.pop_front();
        if (w[DATA_W]) begin
          ref_pairs++;
          ref_zsum = ref_zsum + w[DATA_W-1:0];
        end
      end
      if (do_push) begin
        words_q.push_back({1'b0, in_x});
        words_q.push_back({1'b1, in_z});
        void'(src_q.pop_front());
      end
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic add_pair(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] z);
    src_q.push_back({x, z});
  endtask

  task automatic add_random(input int n);
    for (int i = 0; i < n; i++) add_pair($urandom, $urandom);
  endtask

  initial begin
    // Reset state
    run(2);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single pair
    out_ready = 1'b1;
    add_pair(32'h0000_0005, 32'hFFFF_FFFE);
    run(4);
    chk("single_pair_count", 64'(pair_count), 64'd1);
    chk("single_zsum", 64'(z_sum), 64'hFFFF_FFFE);

    // Fill with stalled output, then drain
    out_ready = 1'b0;
    add_random(5);
    run(7);
    chk("fill_level", 64'(fifo_level), 64'd4);
    chk("fill_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    run(14);

    // Backpressure toggling every cycle
    add_random(4);
    for (int i = 0; i < 24; i++) begin
      out_ready = i[0];
      cycle();
    end
    out_ready = 1'b1;
    run(6);

    // Build level 2, then concurrent pushes and pops
    out_ready = 1'b0;
    add_random(2);
    run(3);
    chk("level_two", 64'(fifo_level), 64'd2);
    out_ready = 1'b1;
    add_random(6);
    run(20);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      if (src_q.size() < 3 && $urandom_range(0, 1) == 1) add_random(1);
      out_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    out_ready = 1'b1;
    run(16);

    // Asynchronous reset between the x and z handshakes
    add_pair(32'h1234_5678, 32'h0BAD_F00D);
    run(2);
    chk("midpair_zpending", 64'(out_last), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", 64'(out_valid), 64'd0);
    chk("areset_data", 64'(out_data), 64'd0);
    chk("areset_last", 64'(out_last), 64'd0);
    chk("areset_count", 64'(pair_count), 64'd0);
    chk("areset_level", 64'(fifo_level), 64'd0);
    words_q.delete();
    src_q.delete();
    ref_pairs = 0;
    ref_zsum  = '0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;

    // Signed wrap of z_sum after reset
    add_pair(32'h0000_00AA, 32'h7FFF_FFFF);
    add_pair(32'h0000_00BB, 32'h0000_0001);
    run(8);
    chk("zsum_wrap", 64'(z_sum), 64'h8000_0000);
    chk("count_after_reset", 64'(pair_count), 64'd2);

    // pair_count wrap: 2 + 62 pairs reaches 2^CNT_W
    add_random(62);
    for (int i = 0; i < 400 && (src_q.size() != 0 || words_q.size() != 0); i++) cycle();
    chk("drained", 64'(words_q.size() + src_q.size()), 64'd0);
    chk("count_wrap", 64'(pair_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_xz_result_serializer
`default_nettype wire
